// File: rtl/cnn_co_scheduler.sv
// cnn_co_scheduler: time-multiplexes one shared accumulate datapath across CO
// output channels. Each accepted window is issued CO times (one strobe per
// weight bank), the CO returned sums get a per-channel bias, ReLU and unsigned
// saturation, and the packed pixel is presented on a valid/ready port.
module cnn_co_scheduler #(
  parameter int CO        = 3,
  parameter int CO_IDX_BW = 2,
  parameter int I_F_BW    = 8,
  parameter int KX        = 5,
  parameter int KY        = 5,
  parameter int ACI_BW    = 21,
  parameter int B_BW      = 16,
  parameter int O_F_BW    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_win_valid,
  output logic                          o_win_ready,
  input  logic [KX*KY*I_F_BW-1:0]       i_window,
  output logic                          o_acc_valid,
  output logic [KX*KY*I_F_BW-1:0]       o_acc_window,
  output logic [CO_IDX_BW-1:0]          o_co_sel,
  input  logic                          i_acc_valid,
  input  logic signed [ACI_BW-1:0]      i_acc_data,
  input  logic [CO*B_BW-1:0]            i_bias,
  output logic                          o_ot_valid,
  input  logic                          i_ot_ready,
  output logic [CO*O_F_BW-1:0]          o_ot_fmap,
  output logic                          o_busy,
  output logic                          o_err
);

  localparam int WIN_W = KX * KY * I_F_BW;
  // Counters must be able to hold CO itself: they stop there instead of wrapping.
  localparam int CNT_W = (CO < 2) ? 1 : $clog2(CO + 1);
  // One extra bit so the bias add can never overflow.
  localparam int S_W   = ACI_BW + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CO - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CO);
  localparam logic signed [S_W-1:0] SAT_MAX = S_W'((1 << O_F_BW) - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_COLLECT,
    S_OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]       coll_cnt_q, coll_cnt_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [CO*O_F_BW-1:0]   fmap_q, fmap_d;
  logic                   err_q, err_d;

  logic signed [B_BW-1:0] bias_sel;
  logic signed [S_W-1:0]  chan_sum;
  logic [O_F_BW-1:0]      chan_pix;
  logic                   coll_en;
  logic                   coll_last;

  // ReLU followed by clamp to the unsigned output range.
  function automatic logic [O_F_BW-1:0] relu_sat(input logic signed [S_W-1:0] s);
    logic [O_F_BW-1:0] r;
    if (s[S_W-1]) begin
      r = '0;
    end else if (s > SAT_MAX) begin
      r = '1;
    end else begin
      r = s[O_F_BW-1:0];
    end
    return r;
  endfunction

  // Pick the bias of the channel whose result is currently returning.
  always_comb begin
    bias_sel = '0;
    for (int c = 0; c < CO; c++) begin
      if (coll_cnt_q == CNT_W'(c)) begin
        bias_sel = i_bias[c*B_BW +: B_BW];
      end
    end
  end

  assign chan_sum = $signed({i_acc_data[ACI_BW-1], i_acc_data})
                  + $signed({{(S_W-B_BW){bias_sel[B_BW-1]}}, bias_sel});
  assign chan_pix = relu_sat(chan_sum);

  // Results are only accepted while a window is in flight and slots remain.
  assign coll_en   = i_acc_valid
                   && ((state_q == S_ISSUE) || (state_q == S_COLLECT))
                   && (coll_cnt_q != CNT_FULL);
  assign coll_last = coll_en && (coll_cnt_q == CNT_LAST);

  // Next-state, counter, capture and collection logic.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    coll_cnt_d  = coll_cnt_q;
    win_d       = win_q;
    fmap_d      = fmap_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_win_valid) begin
          win_d       = i_window;
          issue_cnt_d = '0;
          coll_cnt_d  = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == CNT_LAST) begin
          // A result landing alongside the final strobe may finish the pixel.
          if (coll_last || (coll_cnt_q == CNT_FULL)) begin
            state_d = S_OUT;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (coll_last) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (i_ot_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (coll_en) begin
      coll_cnt_d = coll_cnt_q + 1'b1;
      for (int c = 0; c < CO; c++) begin
        if (coll_cnt_q == CNT_W'(c)) begin
          fmap_d[c*O_F_BW +: O_F_BW] = chan_pix;
        end
      end
    end

    // Results with no window to belong to are dropped but remembered.
    if (i_acc_valid && ((state_q == S_IDLE) || (state_q == S_OUT))) begin
      err_d = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, captured window, output pixel and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt_q <= '0;
      coll_cnt_q  <= '0;
      win_q       <= '0;
      fmap_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      coll_cnt_q  <= coll_cnt_d;
      win_q       <= win_d;
      fmap_q      <= fmap_d;
      err_q       <= err_d;
    end
  end

  assign o_win_ready  = (state_q == S_IDLE);
  assign o_acc_valid  = (state_q == S_ISSUE);
  assign o_co_sel     = (state_q == S_ISSUE) ? CO_IDX_BW'(issue_cnt_q) : '0;
  assign o_acc_window = win_q;
  assign o_ot_valid   = (state_q == S_OUT);
  assign o_ot_fmap    = fmap_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_err        = err_q;

endmodule

// File: doc/cnn_co_scheduler.md
# cnn_co_scheduler

Sequences one shared `cnn_acc_ci` datapath across CO output channels. For each accepted input window, the block issues CO back-to-back accumulate requests, one per output-channel weight bank, and collects the CO channel sums. It adds a per-channel bias, applies ReLU with unsigned saturation, and presents the packed output pixel on a valid/ready port. It sits between the line-buffer/window generator and the pooling stage of each convolution layer.

## Interface
- `CO`, 3: number of output channels (≥1)
- `CO_IDX_BW`, 2: width of channel index (≥ clog2(CO), ≥1)
- `I_F_BW`, 8: input pixel width
- `KX`, 5: kernel width
- `KY`, 5: kernel height
- `ACI_BW`, 21: signed datapath result width
- `B_BW`, 16: signed bias width (≤ ACI_BW)
- `O_F_BW`, 8: unsigned output pixel width (< ACI_BW)

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: **asynchronous, active-high** reset.
- `i_win_valid` in 1: input window valid.
- `o_win_ready` out 1: block can accept a window.
- `i_window` in KX*KY*I_F_BW: window data.
- `o_acc_valid` out 1: issue strobe to datapath `i_in_valid`.
- `o_acc_window` out KX*KY*I_F_BW: captured window to datapath.
- `o_co_sel` out CO_IDX_BW: weight-bank select. The datapath weight mux decodes this combinationally.
- `i_acc_valid` in 1: datapath result valid.
- `i_acc_data` in ACI_BW: signed datapath result.
- `i_bias` in CO*B_BW: signed biases, channel c at `[c*B_BW +: B_BW]`. Quasi-static.
- `o_ot_valid` out 1: output pixel valid.
- `i_ot_ready` in 1: downstream ready.
- `o_ot_fmap` out CO*O_F_BW: channel c at `[c*O_F_BW +: O_F_BW]`.
- `o_busy` out 1: state ≠ IDLE.
- `o_err` out 1: sticky stray-result flag.

## Operation
- FSM states: IDLE, ISSUE, COLLECT, OUT.
- **IDLE:**
  - `o_win_ready`=1.
  - On `i_win_valid`&`o_win_ready`, capture `i_window` into the window register, clear the issue and collect counters, and go to ISSUE.
- **ISSUE:**
  - `o_acc_valid`=1 and `o_co_sel`=issue counter, for exactly CO consecutive cycles (0..CO-1).
  - The datapath samples window and weights in each strobe cycle.
  - After strobe CO-1, go to COLLECT. If all CO results are already collected, go straight to OUT.
- **Collection:**
  - Runs in both ISSUE and COLLECT.
  - Each `i_acc_valid` cycle is result for channel = collect counter; results return in issue order.
  - Computed value: s = sext(`i_acc_data`) + sext(bias[c]) at ACI_BW+1 bits.
  - Output: s<0 → 0; s>2^O_F_BW−1 → 2^O_F_BW−1; else s[O_F_BW-1:0].
  - The computed value is written to the output register slot c, and the collect counter increments.
  - On the CO-th result, go to OUT.
- **OUT:**
  - `o_ot_valid`=1. `o_ot_fmap` is held stable until `i_ot_ready`.
  - On handshake, go to IDLE.
- **Stray results:** `i_acc_valid` in IDLE or OUT is discarded and sets `o_err`. `o_err` is cleared only by reset.
- **Concurrency:** windows are processed strictly one at a time. There is no overlap of windows.

## Timing
- **Reset values** (asynchronous on `reset`=1):
  - state=IDLE.
  - `o_win_ready`=1 (combinational from IDLE, not held low during reset).
  - `o_acc_valid`=0, `o_co_sel`=0, `o_acc_window`=0.
  - `o_ot_valid`=0, `o_ot_fmap`=0.
  - `o_busy`=0, `o_err`=0.
  - Counters=0.
- **Reset mid-operation:**
  - Everything above is restored immediately, and the partial pixel is dropped.
  - The datapath shares `reset`, so no drain is required.
- All outputs are registered or decoded from state/counters only. There is no combinational path from any input to any output except `o_win_ready` (state only).
- **Latency:** window accepted at edge 0. Strobes in cycles 1..CO. With datapath latency L (result L cycles after its strobe), the last result is in cycle CO+L and `o_ot_valid` rises in cycle CO+L+1.
- If `i_ot_ready`=1 on the first OUT cycle, IDLE is reached one cycle later. Minimum window period is CO+L+2 cycles.
- **Boundary conditions:**
  - CO=1 is legal (single strobe).
  - A result may arrive in the same cycle as the final strobe; it is counted.
  - Counters never wrap: they stop at CO.
  - `i_win_valid` outside IDLE is ignored (ready=0).

## Test plan
- **Single window, basic datapath:** CO=3, datapath model L=3 returning results 100, 200, 300, biases 0/0/0; window accepted at edge 0 → strobes in cycles 1..3 with `o_co_sel` 0, 1, 2; `o_ot_valid` in cycle 7; `o_ot_fmap`={255, 200, 100} (ch2..ch0).
- **Bias and ReLU:** results −50, 40, 300; biases 60, −40, −100 → channels 10, 0, 200.
- **Saturation edge:** result 255 with bias 0 → 255; result 256 → 255; result −1 → 0; result −2^20 with bias −2^15 → 0, with no overflow wrap.
- **Backpressure:** `i_ot_ready`=0 for 5 cycles → `o_ot_valid` and `o_ot_fmap` stable; `o_win_ready`=0 and new `i_win_valid` ignored; ready=1 → IDLE on next cycle.
- **Stray and reset:**
  - `i_acc_valid` pulse in IDLE → `o_err`=1, `o_ot_valid` stays 0.
  - `reset` asserted in COLLECT after 1 result → all outputs at reset values next sample; following window processed correctly.
- **L=1 with CO=4:** results overlap issue; all 4 collected; `o_ot_valid` in cycle 6.
